// File: rtl/inv_key_schedule.sv
// -----------------------------------------------------------------------------
// inv_key_schedule
//   Iterative AES-128 inverse key schedule. It accepts the last round key and
//   walks the expansion backwards, presenting round keys NUM_ROUNDS..0 one at a
//   time on a valid/ready stream. Each step undoes one forward expansion round.
//   While the consumer keeps rk_ready high, it delivers one key per cycle.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle request, sampled only in IDLE
//   key_in    round-NUM_ROUNDS key, captured on an accepted start
//   rk_out    current round key, word0 in [127:96]
//   rk_round  round index of rk_out
//   rk_valid  rk_out/rk_round valid
//   rk_ready  consumer accepts the current key
//   busy      high while keys are being emitted
//   done      one-cycle pulse after the round-0 key is accepted
//
// States
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for start; outputs hold their last values
//   EMIT    | key_q/round_q are presented; steps back one round per transfer
//
// Also holds the byte substitution unit sbox, instantiated four times.
// -----------------------------------------------------------------------------

module sbox (
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      logic [7:0] bb;
      acc = 8'h00;
      aa  = a;
      bb  = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) acc = acc ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254, which also maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   logic [7:0] inv_b;

   assign inv_b  = ginv(byte_i);
   assign byte_o = inv_b ^ rotl(inv_b, 1) ^ rotl(inv_b, 2) ^ rotl(inv_b, 3)
                 ^ rotl(inv_b, 4) ^ 8'h63;

endmodule

module inv_key_schedule #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done
);

   typedef enum logic {
      ST_IDLE,
      ST_EMIT
   } state_e;

   state_e       state_q;
   logic [127:0] key_q;
   logic [3:0]   round_q;
   logic         valid_q;
   logic         busy_q;
   logic         done_q;

   logic [127:0] key_d;
   logic [31:0]  w0p, w1p, w2p, w3p;
   logic [31:0]  w0, w1, w2, w3;
   logic [7:0]   sb0, sb1, sb2, sb3;
   logic [31:0]  t_word;
   logic [3:0]   fwd_round;

   // Round constant of forward round r; rounds beyond 9 carry no constant.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd0:    rc = 8'h01;
         4'd1:    rc = 8'h02;
         4'd2:    rc = 8'h04;
         4'd3:    rc = 8'h08;
         4'd4:    rc = 8'h10;
         4'd5:    rc = 8'h20;
         4'd6:    rc = 8'h40;
         4'd7:    rc = 8'h80;
         4'd8:    rc = 8'h1b;
         4'd9:    rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   assign w0p = key_q[127:96];
   assign w1p = key_q[95:64];
   assign w2p = key_q[63:32];
   assign w3p = key_q[31:0];

   // Words 1..3 fall out of the forward XOR chain. Word 0 then needs the
   // recovered (older) word 3 for its SubWord/RotWord term.
   assign w3 = w3p ^ w2p;
   assign w2 = w2p ^ w1p;
   assign w1 = w1p ^ w0p;

   sbox u_sbox0 (.byte_i(w3[7:0]),   .byte_o(sb0));
   sbox u_sbox1 (.byte_i(w3[15:8]),  .byte_o(sb1));
   sbox u_sbox2 (.byte_i(w3[23:16]), .byte_o(sb2));
   sbox u_sbox3 (.byte_i(w3[31:24]), .byte_o(sb3));

   assign t_word    = {sb2, sb1, sb0, sb3};
   // The key held in key_q was produced by forward round round_q-1. The value
   // is unused when round_q is 0.
   assign fwd_round = round_q - 4'd1;
   assign w0        = w0p ^ t_word ^ {rcon(fwd_round), 24'h000000};
   assign key_d     = {w0, w1, w2, w3};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         round_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  key_q   <= key_in;
                  round_q <= 4'(NUM_ROUNDS);
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (rk_ready) begin
                  if (round_q != 4'd0) begin
                     key_q   <= key_d;
                     round_q <= round_q - 4'd1;
                  end else begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign rk_out   = key_q;
   assign rk_round = round_q;
   assign rk_valid = valid_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_inv_key_schedule
//   Self-checking bench for inv_key_schedule. The reference builds the forward
//   AES-128 key expansion from K0, using a table S-box and doubled round
//   constants. A cycle model of the stream then tracks which chain entry must
//   be on the outputs. Hand-computed FIPS-197 values pin the reference itself.
// -----------------------------------------------------------------------------

module tb_inv_key_schedule;

   localparam logic [127:0] STD_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] STD_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] STD_K9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] STD_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key_in = '0;
   logic [127:0] rk_out;
   logic [3:0]   rk_round;
   logic         rk_valid;
   logic         rk_ready = 1'b0;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   inv_key_schedule #(.NUM_ROUNDS(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .key_in   (key_in),
      .rk_out   (rk_out),
      .rk_round (rk_round),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // ---------------- reference key expansion ----------------
   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [2047:0] t;
      int idx;
      t   = SBOX_TBL;
      idx = 2047 - 8 * int'(x);
      return t[idx -: 8];
   endfunction

   function automatic logic [31:0] sub_rot(input logic [31:0] w);
      return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
   endfunction

   logic [127:0] fwd [0:10];
   logic [127:0] pend_chain [0:10];

   task automatic expand(input logic [127:0] k0);
      logic [31:0] w [0:43];
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         if (i % 4 == 0) begin
            w[i] = w[i-4] ^ sub_rot(w[i-1]) ^ {rc, 24'h000000};
            rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else begin
            w[i] = w[i-4] ^ w[i-1];
         end
      end
      for (int r = 0; r <= 10; r++) fwd[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // ---------------- stream model ----------------
   bit           m_active = 1'b0;
   bit           m_done = 1'b0;
   int           m_round = 0;
   logic [127:0] m_chain [0:10];

   initial for (int i = 0; i <= 10; i++) m_chain[i] = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_round  = 0;
         for (int i = 0; i <= 10; i++) m_chain[i] = '0;
      end else begin
         m_done = 1'b0;
         if (!m_active) begin
            if (start) begin
               m_active = 1'b1;
               m_round  = 10;
               m_chain  = pend_chain;
            end
         end else if (rk_ready) begin
            if (m_round == 0) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end else begin
               m_round = m_round - 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [127:0] exp_out;
      exp_out = m_chain[m_round];
      checks++;
      if (rk_valid !== m_active || busy !== m_active || done !== m_done ||
          rk_round !== 4'(m_round) || rk_out !== exp_out) begin
         errors++;
         $display("FAIL cycle_model t=%0t got v=%b b=%b d=%b r=%0d k=%h expected v=%b b=%b d=%b r=%0d k=%h",
                  $time, rk_valid, busy, done, rk_round, rk_out,
                  m_active, m_active, m_done, m_round, exp_out);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic launch(input logic [127:0] k0);
      expand(k0);
      pend_chain = fwd;
      key_in     = fwd[10];
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   logic [127:0] got [0:10];
   int           xfers;
   bit           done_seen;

   // Records every transfer until done is seen; ends on the negedge where
   // done is high.
   task automatic collect(input int max_cyc, input bit rand_rdy);
      xfers     = 0;
      done_seen = 1'b0;
      for (int i = 0; i <= 10; i++) got[i] = '0;
      for (int c = 0; c < max_cyc && !done_seen; c++) begin
         @(negedge clk);
         if (done) begin
            done_seen = 1'b1;
         end else begin
            if (rk_valid && rk_ready && rk_round <= 4'd10) begin
               got[rk_round] = rk_out;
               xfers++;
            end
            if (rand_rdy) rk_ready = ($urandom_range(0, 3) != 0);
         end
      end
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL collect_timeout: got no done within %0d cycles expected done", max_cyc);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [127:0] k;
      bit           found;

      repeat (3) @(negedge clk);
      chk("reset_rk_out", rk_out, '0);
      chk("reset_flags", 128'({rk_round, rk_valid, busy, done}), '0);
      rst_n = 1'b1;

      expand(STD_K0);
      chk("ref_k10", fwd[10], STD_K10);
      chk("ref_k9", fwd[9], STD_K9);
      chk("ref_k1", fwd[1], STD_K1);

      // FIPS-197 walk with the consumer always ready
      rk_ready = 1'b1;
      launch(STD_K0);
      collect(40, 1'b0);
      chk("fips_r10", got[10], STD_K10);
      chk("fips_r9", got[9], STD_K9);
      chk("fips_r1", got[1], STD_K1);
      chk("fips_r0", got[0], STD_K0);
      chk("fips_xfers", 128'(xfers), 128'd11);

      // start in the same cycle as done
      k = rand128();
      launch(k);
      @(negedge clk);
      chk("b2b_valid", 128'(rk_valid), 128'd1);
      chk("b2b_round", 128'(rk_round), 128'd10);
      chk("b2b_key", rk_out, fwd[10]);
      collect(40, 1'b0);
      chk("b2b_r0", got[0], k);

      // backpressure while round 9 is shown
      launch(STD_K0);
      @(negedge clk);
      @(negedge clk);
      rk_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_round", 128'(rk_round), 128'd9);
         chk("bp_key", rk_out, STD_K9);
         chk("bp_valid", 128'(rk_valid), 128'd1);
      end
      rk_ready = 1'b1;
      collect(40, 1'b0);
      chk("bp_xfers", 128'(xfers), 128'd9);
      chk("bp_r1", got[1], STD_K1);
      chk("bp_r0", got[0], STD_K0);

      // start during EMIT is ignored
      launch(STD_K0);
      @(negedge clk);
      @(negedge clk);
      key_in = 128'hdeadbeef_01234567_89abcdef_fedcba98;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      chk("ign_busy", 128'(busy), 128'd1);
      chk("ign_round", 128'(rk_round), 128'd8);
      collect(40, 1'b0);
      chk("ign_xfers", 128'(xfers), 128'd8);
      chk("ign_r0", got[0], STD_K0);

      // reset while round 5 is presented
      launch(rand128());
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         if (rk_round == 4'd5 && rk_valid) found = 1'b1;
      end
      chk("rst_reach_r5", 128'(found), 128'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_rk_out", rk_out, '0);
      chk("rst_mid_flags", 128'({rk_round, rk_valid, busy, done}), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      k = rand128();
      launch(k);
      @(negedge clk);
      chk("rst_restart_round", 128'(rk_round), 128'd10);
      chk("rst_restart_key", rk_out, fwd[10]);
      collect(40, 1'b0);
      chk("rst_restart_r0", got[0], k);

      // forward cross-check with random keys and random backpressure
      for (int n = 0; n < 100; n++) begin
         k = rand128();
         launch(k);
         collect(300, 1'b1);
         chk("rand_r0", got[0], k);
         chk("rand_xfers", 128'(xfers), 128'd11);
      end
      rk_ready = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
